// File: rtl/fp_result_buffer_pkg.sv
// fp_result_buffer_pkg: shared FPU flag indices, tracker state encoding and canonical NaNs
package fp_result_buffer_pkg;

    localparam int FF_W  = 5;
    localparam int FF_NV = 4;
    localparam int FF_DZ = 3;
    localparam int FF_OF = 2;
    localparam int FF_UF = 1;
    localparam int FF_NX = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SQUASH = 2'd2
    } trk_state_e;

    localparam logic [31:0] CANON_NAN_S = 32'h7fc0_0000;
    localparam logic [63:0] CANON_NAN_D = 64'h7ff8_0000_0000_0000;

    function automatic logic [FF_W-1:0] pack_flags(input logic nv, input logic dz,
                                                  input logic of, input logic uf,
                                                  input logic nx);
        logic [FF_W-1:0] f;
        f        = '0;
        f[FF_NV] = nv;
        f[FF_DZ] = dz;
        f[FF_OF] = of;
        f[FF_UF] = uf;
        f[FF_NX] = nx;
        return f;
    endfunction

endpackage

// File: rtl/fp_wb_fifo.sv
// fp_wb_fifo: synchronous FIFO with push, pop, flush and occupancy count
module fp_wb_fifo #(
    parameter int W     = 42,
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [W-1:0]  head_data,
    output logic          head_valid,
    output logic [AW:0]   count
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_pop;

    always_comb begin
        head_valid = count_q != '0;
        do_pop     = pop && head_valid;
        mem_d      = mem_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                mem_d[wptr_q] = push_data;
                wptr_d        = wptr_q + AW'(1);
            end
            rptr_d  = do_pop ? rptr_q + AW'(1) : rptr_q;
            count_d = count_q + (AW+1)'(push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Empty head reads as zero so the storage itself never needs a reset.
    assign head_data = head_valid ? mem_q[rptr_q] : '0;
    assign count     = count_q;

endmodule

// File: rtl/fp_result_buffer.sv
// fp_result_buffer: issues ops to an FP unit, buffers results for writeback, accrues fflags
module fp_result_buffer
    import fp_result_buffer_pkg::*;
#(
    parameter int FLEN  = 32,
    parameter int DEPTH = 2,
    parameter int RD_W  = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_valid,
    input  logic [RD_W-1:0] issue_rd,
    output logic            issue_ready,
    output logic            unit_start,
    input  logic            unit_done,
    input  logic [FLEN-1:0] unit_result,
    input  logic            unit_flag_nv,
    input  logic            unit_flag_of,
    input  logic            unit_flag_uf,
    input  logic            unit_flag_nx,
    input  logic            flush,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [RD_W-1:0] wb_rd,
    output logic [FLEN-1:0] wb_data,
    output logic [FF_W-1:0] wb_flags,
    input  logic            csr_we,
    input  logic [FF_W-1:0] csr_wdata,
    output logic [FF_W-1:0] fflags,
    output logic            proto_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = RD_W + FLEN + FF_W;
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    trk_state_e      state_q, state_d;
    logic [RD_W-1:0] rd_q, rd_d;
    logic [FF_W-1:0] fflags_q, fflags_d;
    logic            proto_err_q, proto_err_d;
    logic [AW:0]     count;
    logic [EW-1:0]   head;
    logic [EW-1:0]   push_data;
    logic            push;
    logic            pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = unit_start ? WAIT : IDLE;
            WAIT:    state_d = unit_done ? IDLE : (flush ? SQUASH : WAIT);
            SQUASH:  state_d = unit_done ? IDLE : SQUASH;
            default: state_d = IDLE;
        endcase
    end

    // Credit check: an op only starts when a FIFO slot is guaranteed for its result.
    always_comb begin
        issue_ready = (state_q == IDLE) && (count < CNT_FULL);
        unit_start  = issue_valid && issue_ready;
        push        = (state_q == WAIT) && unit_done && !flush;
    end

    always_comb begin
        rd_d        = unit_start ? issue_rd : rd_q;
        proto_err_d = proto_err_q || (unit_done && state_q == IDLE);
        pop         = wb_valid && wb_ready && !flush;
        fflags_d    = csr_we ? csr_wdata : (pop ? fflags_q | wb_flags : fflags_q);
        push_data   = {rd_q, unit_result,
                       pack_flags(unit_flag_nv, 1'b0, unit_flag_of, unit_flag_uf, unit_flag_nx)};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q        <= '0;
            fflags_q    <= '0;
            proto_err_q <= 1'b0;
        end else begin
            rd_q        <= rd_d;
            fflags_q    <= fflags_d;
            proto_err_q <= proto_err_d;
        end
    end

    fp_wb_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_data  (push_data),
        .pop        (pop),
        .flush      (flush),
        .head_data  (head),
        .head_valid (wb_valid),
        .count      (count)
    );

    assign {wb_rd, wb_data, wb_flags} = head;
    assign fflags    = fflags_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_fp_result_buffer.sv
// tb_fp_result_buffer: directed scoreboard bench for fp_result_buffer
module tb_fp_result_buffer;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [4:0]  flags;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        issue_ready;
    logic        unit_start;
    logic        unit_done = 1'b0;
    logic [31:0] unit_result = '0;
    logic        unit_flag_nv = 1'b0;
    logic        unit_flag_of = 1'b0;
    logic        unit_flag_uf = 1'b0;
    logic        unit_flag_nx = 1'b0;
    logic        flush = 1'b0;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  wb_flags;
    logic        csr_we = 1'b0;
    logic [4:0]  csr_wdata = '0;
    logic [4:0]  fflags;
    logic        proto_err;

    int   tests = 0;
    int   fails = 0;
    ent_t sb[$];
    logic [4:0] exp_ff = '0;

    fp_result_buffer #(.FLEN(32), .DEPTH(2), .RD_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_ready  (issue_ready),
        .unit_start   (unit_start),
        .unit_done    (unit_done),
        .unit_result  (unit_result),
        .unit_flag_nv (unit_flag_nv),
        .unit_flag_of (unit_flag_of),
        .unit_flag_uf (unit_flag_uf),
        .unit_flag_nx (unit_flag_nx),
        .flush        (flush),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .wb_flags     (wb_flags),
        .csr_we       (csr_we),
        .csr_wdata    (csr_wdata),
        .fflags       (fflags),
        .proto_err    (proto_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [4:0] rd);
        issue_valid = 1'b1;
        issue_rd    = rd;
        #1;
        chk("issue_start", unit_start, 1'b1);
        tick();
        issue_valid = 1'b0;
        chk("busy_not_ready", issue_ready, 1'b0);
    endtask

    task automatic done(input logic [31:0] data, input logic [4:0] f, input bit expect_push);
        ent_t e;
        unit_done    = 1'b1;
        unit_result  = data;
        unit_flag_nv = f[4];
        unit_flag_of = f[2];
        unit_flag_uf = f[1];
        unit_flag_nx = f[0];
        if (expect_push) begin
            e.rd    = issue_rd;
            e.data  = data;
            e.flags = {f[4], 1'b0, f[2:0]};
            sb.push_back(e);
        end
        tick();
        unit_done = 1'b0;
        {unit_flag_nv, unit_flag_of, unit_flag_uf, unit_flag_nx} = '0;
    endtask

    task automatic drain_one(input string tag, input bit csr, input logic [4:0] wd);
        ent_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s scoreboard empty observed=%0d expected=1", tag, wb_valid);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_valid"}, wb_valid, 1'b1);
        chk({tag, "_rd"}, wb_rd, e.rd);
        chk({tag, "_data"}, wb_data, e.data);
        chk({tag, "_flags"}, wb_flags, e.flags);
        wb_ready  = 1'b1;
        csr_we    = csr;
        csr_wdata = wd;
        tick();
        wb_ready = 1'b0;
        csr_we   = 1'b0;
        exp_ff   = csr ? wd : (exp_ff | e.flags);
        chk({tag, "_fflags"}, fflags, exp_ff);
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_wb_rd", wb_rd, 5'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_flags", wb_flags, 5'd0);
        chk("rst_fflags", fflags, 5'd0);
        chk("rst_proto_err", proto_err, 1'b0);
        chk("rst_issue_ready", issue_ready, 1'b1);
        chk("rst_unit_start", unit_start, 1'b0);

        issue(5'd3);
        done(32'h4040_0000, 5'h00, 1'b1);
        drain_one("basic", 1'b0, 5'h00);
        chk("basic_empty", wb_valid, 1'b0);

        issue(5'd1);
        done(32'h3f80_0000, 5'h01, 1'b1);
        issue(5'd2);
        done(32'h4000_0000, 5'h05, 1'b1);
        chk("full_not_ready", issue_ready, 1'b0);
        drain_one("bp_first", 1'b0, 5'h00);
        chk("credit_back", issue_ready, 1'b1);
        drain_one("bp_second", 1'b0, 5'h00);
        chk("accrue_05", fflags, 5'h05);

        issue(5'd4);
        done(32'h7fc0_0000, 5'h10, 1'b1);
        drain_one("csr_wins", 1'b1, 5'h00);
        csr_we    = 1'b1;
        csr_wdata = 5'h12;
        tick();
        csr_we = 1'b0;
        exp_ff = 5'h12;
        chk("csr_write", fflags, exp_ff);

        issue(5'd5);
        done(32'h1111_1111, 5'h00, 1'b1);
        issue(5'd6);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        sb.delete();
        chk("flush_empty", wb_valid, 1'b0);
        chk("squash_not_ready", issue_ready, 1'b0);
        tick();
        chk("squash_hold", issue_ready, 1'b0);
        done(32'h2222_2222, 5'h01, 1'b0);
        chk("squash_no_push", wb_valid, 1'b0);
        chk("squash_ready", issue_ready, 1'b1);
        chk("squash_no_perr", proto_err, 1'b0);

        issue(5'd7);
        flush = 1'b1;
        done(32'h3333_3333, 5'h01, 1'b0);
        flush = 1'b0;
        chk("flush_done_no_push", wb_valid, 1'b0);
        chk("flush_done_ready", issue_ready, 1'b1);

        issue(5'd8);
        done(32'h4444_4444, 5'h01, 1'b1);
        chk("pre_flush_valid", wb_valid, 1'b1);
        wb_ready = 1'b1;
        flush    = 1'b1;
        tick();
        wb_ready = 1'b0;
        flush    = 1'b0;
        sb.delete();
        chk("flush_pop_ignored", fflags, exp_ff);
        chk("flush_pop_empty", wb_valid, 1'b0);

        unit_done = 1'b1;
        tick();
        unit_done = 1'b0;
        chk("perr_no_push", wb_valid, 1'b0);
        chk("perr_set", proto_err, 1'b1);
        tick();
        tick();
        tick();
        chk("perr_sticky", proto_err, 1'b1);

        issue(5'd9);
        done(32'h5555_5555, 5'h04, 1'b1);
        issue(5'd10);
        reset = 1'b1;
        tick();
        sb.delete();
        exp_ff = '0;
        chk("mrst_wb_valid", wb_valid, 1'b0);
        chk("mrst_wb_rd", wb_rd, 5'd0);
        chk("mrst_wb_data", wb_data, 32'd0);
        chk("mrst_wb_flags", wb_flags, 5'd0);
        chk("mrst_fflags", fflags, exp_ff);
        chk("mrst_proto_err", proto_err, 1'b0);
        chk("mrst_issue_ready", issue_ready, 1'b1);
        chk("mrst_unit_start", unit_start, 1'b0);
        reset = 1'b0;
        tick();
        unit_done = 1'b1;
        tick();
        unit_done = 1'b0;
        chk("abandoned_perr", proto_err, 1'b1);
        chk("abandoned_no_push", wb_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
